mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_starve_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Arbiter state encoding, port ownership and starvation-guard defaults.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_I,
        HOLD_D,
        WAIT_I,
        WAIT_D
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int         ARB_STARVE_MAX_DEF = 4;
    localparam int         ARB_STARVE_CNT_W   = 4;
    localparam logic [7:0] ARB_BE_ALL         = 8'hFF;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts grants to a competing port while the
// waiting port is pending and raises force_waiter once the limit is reached.
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic waiter_req,
    input  logic waiter_gnt,
    input  logic other_gnt,
    output logic force_waiter
);

    localparam logic [ARB_STARVE_CNT_W-1:0] MAX_C = ARB_STARVE_CNT_W'(STARVE_MAX);

    logic [ARB_STARVE_CNT_W-1:0] cnt_q;

    // A waiter that is served or withdraws owes nothing; restart the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (waiter_gnt || !waiter_req) begin
            cnt_q <= '0;
        end else if (other_gnt && (cnt_q < MAX_C)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign force_waiter = (cnt_q >= MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and LSU (D).
// Define MEM_ARB_PERF_CNT_EN to build the per-port stall counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [7:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       perf_i_stall_o,
    output logic [31:0]       perf_d_stall_o,
    output arb_state_t        dbg_state
);

    // Handshake: a requester holds req and payload stable until it sees gnt;
    // gnt is the same-cycle acceptance, rvalid the single-cycle response.

    arb_state_t state_q, state_d;
    arb_owner_t sel;
    logic       force_i;
    logic       i_hi_q;
    logic       pick_d;

    mem_port_arbiter_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .waiter_req  (i_req_i),
        .waiter_gnt  (i_gnt_o),
        .other_gnt   (d_gnt_o),
        .force_waiter(force_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_hi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_gnt_o) begin
                i_hi_q <= i_addr_i[2];
            end
        end
    end

    assign dbg_state = state_q;

    // D wins unless fetch is starved; a lone D request always wins.
    assign pick_d = d_req_i && (!force_i || !i_req_i);

    always_comb begin
        state_d    = state_q;
        sel        = OWN_I;
        mem_req_o  = 1'b0;
        i_gnt_o    = 1'b0;
        d_gnt_o    = 1'b0;
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (i_req_i || d_req_i) begin
                        mem_req_o = 1'b1;
                        sel       = pick_d ? OWN_D : OWN_I;
                        if (mem_gnt_i) begin
                            i_gnt_o = !pick_d;
                            d_gnt_o = pick_d;
                            state_d = pick_d ? WAIT_D : WAIT_I;
                        end else begin
                            state_d = pick_d ? HOLD_D : HOLD_I;
                        end
                    end
                end
                HOLD_I: begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) begin
                        i_gnt_o = 1'b1;
                        state_d = WAIT_I;
                    end
                end
                HOLD_D: begin
                    mem_req_o = 1'b1;
                    sel       = OWN_D;
                    if (mem_gnt_i) begin
                        d_gnt_o = 1'b1;
                        state_d = WAIT_D;
                    end
                end
                WAIT_I: begin
                    if (mem_rvalid_i) begin
                        i_rvalid_o = 1'b1;
                        state_d    = IDLE;
                    end
                end
                WAIT_D: begin
                    if (mem_rvalid_i) begin
                        d_rvalid_o = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel == OWN_D) begin
                mem_we_o    = d_we_i;
                mem_be_o    = d_be_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
            end else begin
                mem_be_o   = ARB_BE_ALL;
                mem_addr_o = i_addr_i;
            end
        end
    end

    assign i_rdata_o = i_rvalid_o ? (i_hi_q ? mem_rdata_i[32 +: 32] : mem_rdata_i[0 +: 32]) : '0;
    assign d_rdata_o = d_rvalid_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else begin
            if (i_req_i && !i_gnt_o) perf_i_q <= perf_i_q + 32'd1;
            if (d_req_i && !d_gnt_o) perf_d_q <= perf_d_q + 32'd1;
        end
    end

    assign perf_i_stall_o = perf_i_q;
    assign perf_d_stall_o = perf_d_q;
`else
    assign perf_i_stall_o = '0;
    assign perf_d_stall_o = '0;
`endif

`ifndef SYNTHESIS
    // A response still in flight when reset hit may land before the next grant.
    logic stale_ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_ok_q <= 1'b1;
        end else if (i_gnt_o || d_gnt_o) begin
            stale_ok_q <= 1'b0;
        end
    end

    a_i_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == HOLD_I) |-> i_req_i);
    a_d_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == HOLD_D) |-> d_req_i);
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        ((state_q == IDLE || state_q == HOLD_I || state_q == HOLD_D) && !stale_ok_q)
        |-> !mem_rvalid_i);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_gnt_o, i_rvalid_o;
    logic [31:0]       i_rdata_o;
    logic              d_req_i, d_we_i;
    logic [7:0]        d_be_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o, d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [7:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [31:0]       perf_i_stall_o, perf_d_stall_o;
    arb_state_t        dbg_state;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .perf_i_stall_o(perf_i_stall_o), .perf_d_stall_o(perf_d_stall_o),
        .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_req_i = 0; i_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        step();
        drive_idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic [63:0] i_addr;
        logic [63:0] d_addr;
        logic        d_we;
        logic [7:0]  d_be;
        logic [63:0] d_wdata;
        logic [63:0] rdata;
        logic        exp_d_win;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [31:0] exp_i_rdata;
        logic [63:0] exp_d_rdata;
    } vec_t;

    vec_t tbl[5];

    // randomized-phase model state
    int          m_phase;
    bit          m_own_d, m_i_hi;
    int          m_starve;
    bit          i_pend, d_pend, mem_out;
    int          mem_lat, nxt;
    logic [63:0] ia, da, dw;
    logic        dwe;
    logic [7:0]  dbe;
    logic        e_ig, e_dg, e_ir, e_dr, e_req;
    logic [31:0] pi_m, pd_m;
    logic [9:0]  seq;
    int          ng;
    bit          rv_next;

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 64'h4, 64'h0, 1'b0, 8'h00, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                   1'b0, 64'h4, 1'b0, 8'hFF, 64'h0, 32'hAAAA_BBBB, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 8'h00, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                   1'b0, 64'h0, 1'b0, 8'hFF, 64'h0, 32'hCCCC_DDDD, 64'h0};
        tbl[2] = '{1'b0, 1'b1, 64'h0, 64'h1000, 1'b0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF,
                   1'b1, 64'h1000, 1'b0, 8'hFF, 64'h0, 32'h0, 64'h0123_4567_89AB_CDEF};
        tbl[3] = '{1'b0, 1'b1, 64'h0, 64'h2008, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 64'h0,
                   1'b1, 64'h2008, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 32'h0, 64'h0};
        tbl[4] = '{1'b1, 1'b1, 64'h10C, 64'h3000, 1'b0, 8'hF0, 64'h0, 64'h0123_4567_89AB_CDEF,
                   1'b1, 64'h3000, 1'b0, 8'hF0, 64'h0, 32'h0123_4567, 64'h0123_4567_89AB_CDEF};

        // reset with every request asserted: outputs must stay quiet
        drive_idle();
        rst = 1;
        i_req_i = 1; i_addr_i = 64'h8; d_req_i = 1; d_addr_i = 64'h10; mem_gnt_i = 1;
        step();
        settle();
        chk("rst_i_gnt", i_gnt_o, 0);
        chk("rst_d_gnt", d_gnt_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_i_rvalid", i_rvalid_o, 0);
        chk("rst_d_rvalid", d_rvalid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_perf_i", perf_i_stall_o, 0);
        chk("rst_perf_d", perf_d_stall_o, 0);
        drive_idle();
        step();
        rst = 0;

        // vector table: one transaction per row, loser (if any) served after
        for (int k = 0; k < 5; k++) begin
            step();
            i_req_i = tbl[k].i_req; i_addr_i = tbl[k].i_addr;
            d_req_i = tbl[k].d_req; d_addr_i = tbl[k].d_addr; d_we_i = tbl[k].d_we;
            d_be_i = tbl[k].d_be; d_wdata_i = tbl[k].d_wdata;
            mem_gnt_i = 1; mem_rvalid_i = 0;
            settle();
            chk("tbl_i_gnt", i_gnt_o, !tbl[k].exp_d_win);
            chk("tbl_d_gnt", d_gnt_o, tbl[k].exp_d_win);
            chk("tbl_mem_req", mem_req_o, 1);
            chk("tbl_mem_addr", mem_addr_o, tbl[k].exp_addr);
            chk("tbl_mem_we", mem_we_o, tbl[k].exp_we);
            chk("tbl_mem_be", mem_be_o, tbl[k].exp_be);
            chk("tbl_mem_wdata", mem_wdata_o, tbl[k].exp_wdata);
            step();
            if (tbl[k].exp_d_win) d_req_i = 0; else i_req_i = 0;
            mem_gnt_i = 0;
            settle();
            chk("tbl_wait_req", mem_req_o, 0);
            chk("tbl_wait_state", dbg_state, tbl[k].exp_d_win ? WAIT_D : WAIT_I);
            chk("tbl_wait_rv", {i_rvalid_o, d_rvalid_o}, 0);
            step();
            mem_rvalid_i = 1; mem_rdata_i = tbl[k].rdata;
            settle();
            chk("tbl_i_rvalid", i_rvalid_o, !tbl[k].exp_d_win);
            chk("tbl_d_rvalid", d_rvalid_o, tbl[k].exp_d_win);
            if (tbl[k].exp_d_win) chk("tbl_d_rdata", d_rdata_o, tbl[k].exp_d_rdata);
            else chk("tbl_i_rdata", i_rdata_o, tbl[k].exp_i_rdata);
            if (tbl[k].i_req && tbl[k].d_req) begin
                step();
                mem_rvalid_i = 0; mem_gnt_i = 1;
                settle();
                chk("tbl_loser_i_gnt", i_gnt_o, 1);
                chk("tbl_loser_addr", mem_addr_o, tbl[k].i_addr);
                step();
                i_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
                settle();
                chk("tbl_loser_rvalid", i_rvalid_o, 1);
                chk("tbl_loser_rdata", i_rdata_o, tbl[k].exp_i_rdata);
            end
            step();
            drive_idle();
        end

        // starvation guard: both ports request continuously
        do_reset();
        seq = '0; ng = 0; rv_next = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            step();
            i_req_i = 1; i_addr_i = 64'h40; d_req_i = 1; d_addr_i = 64'h80; d_be_i = 8'hFF;
            mem_gnt_i = 1; mem_rvalid_i = rv_next; mem_rdata_i = 64'h5;
            settle();
            rv_next = 0;
            if (i_gnt_o || d_gnt_o) begin
                seq = {seq[8:0], d_gnt_o};
                ng++;
                rv_next = 1;
            end
        end
        chk("starve_count", ng, 10);
        chk("starve_seq", seq, 10'b1111011110);

        // owner lock: D arrives while I holds the port
        do_reset();
        step();
        i_req_i = 1; i_addr_i = 64'h104; mem_gnt_i = 0;
        settle();
        chk("lock_addr_0", mem_addr_o, 64'h104);
        for (int c = 1; c < 3; c++) begin
            step();
            d_req_i = 1; d_addr_i = 64'h5000; d_be_i = 8'hFF; d_we_i = 0;
            settle();
            chk("lock_addr", mem_addr_o, 64'h104);
            chk("lock_gnts", {i_gnt_o, d_gnt_o}, 0);
        end
        step();
        mem_gnt_i = 1;
        settle();
        chk("lock_i_gnt", i_gnt_o, 1);
        chk("lock_d_gnt", d_gnt_o, 0);
        chk("lock_addr_g", mem_addr_o, 64'h104);
        step();
        i_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        settle();
        chk("lock_i_rvalid", i_rvalid_o, 1);
        chk("lock_i_rdata", i_rdata_o, 32'hDEAD_BEEF);
        chk("lock_d_quiet", {d_gnt_o, d_rvalid_o}, 0);
        step();
        mem_rvalid_i = 0; mem_gnt_i = 1;
        settle();
        chk("lock_d_gnt_after", d_gnt_o, 1);
        chk("lock_d_addr", mem_addr_o, 64'h5000);
        step();
        d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        settle();
        chk("lock_d_rvalid", d_rvalid_o, 1);
        chk("lock_i_rvalid_q", i_rvalid_o, 0);

        // reset while WAIT_D, stale response after release
        do_reset();
        step();
        d_req_i = 1; d_addr_i = 64'h7000; d_be_i = 8'hFF; mem_gnt_i = 1;
        settle();
        chk("rw_d_gnt", d_gnt_o, 1);
        step();
        d_req_i = 0; mem_gnt_i = 0;
        settle();
        chk("rw_state_wait", dbg_state, WAIT_D);
        step();
        rst = 1;
        settle();
        chk("rw_state_rst", dbg_state, IDLE);
        step();
        rst = 0;
        step();
        mem_rvalid_i = 1; mem_rdata_i = 64'h1234;
        settle();
        chk("rw_stale_d_rv", d_rvalid_o, 0);
        chk("rw_stale_i_rv", i_rvalid_o, 0);
        chk("rw_state_idle", dbg_state, IDLE);
        chk("rw_perf_i", perf_i_stall_o, 0);
        chk("rw_perf_d", perf_d_stall_o, 0);
        step();
        mem_rvalid_i = 0;
        settle();
        chk("rw_state_after", dbg_state, IDLE);

        // randomized traffic against the transaction-level model
        do_reset();
        m_phase = 0; m_starve = 0; m_own_d = 0; m_i_hi = 0;
        i_pend = 0; d_pend = 0; mem_out = 0; mem_lat = 0;
        ia = '0; da = '0; dw = '0; dwe = 0; dbe = '0;
        pi_m = '0; pd_m = '0;
        for (int c = 0; c < 450; c++) begin
            step();
            if (c < 400 && !i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                ia = {$urandom, $urandom} & ~64'h3;
            end
            if (c < 400 && !d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                da = {$urandom, $urandom};
                dw = {$urandom, $urandom};
                dwe = 1'($urandom_range(0, 1));
                dbe = 8'($urandom);
            end
            i_req_i = i_pend; i_addr_i = ia;
            d_req_i = d_pend; d_addr_i = da; d_wdata_i = dw; d_we_i = dwe; d_be_i = dbe;
            mem_gnt_i = 1'($urandom_range(0, 1));
            mem_rvalid_i = 0;
            mem_rdata_i = {$urandom, $urandom};
            if (mem_out) begin
                if (mem_lat == 0) begin
                    mem_rvalid_i = 1;
                    mem_out = 0;
                end else begin
                    mem_lat--;
                end
            end
            settle();

            e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_req = 0;
            if (m_phase == 0 && (i_pend || d_pend)) begin
                if (d_pend && m_starve < STARVE_MAX) m_own_d = 1;
                else if (i_pend) m_own_d = 0;
                else m_own_d = 1;
                m_phase = 1;
            end
            nxt = m_phase;
            if (m_phase == 1) begin
                e_req = 1;
                if (mem_gnt_i) begin
                    e_ig = !m_own_d;
                    e_dg = m_own_d;
                    if (!m_own_d) m_i_hi = ia[2];
                    nxt = 2;
                end
            end else if (m_phase == 2) begin
                if (mem_rvalid_i) begin
                    e_ir = !m_own_d;
                    e_dr = m_own_d;
                    nxt = 0;
                end
            end

            chk("rnd_i_gnt", i_gnt_o, e_ig);
            chk("rnd_d_gnt", d_gnt_o, e_dg);
            chk("rnd_mem_req", mem_req_o, e_req);
            chk("rnd_i_rvalid", i_rvalid_o, e_ir);
            chk("rnd_d_rvalid", d_rvalid_o, e_dr);
            if (e_req) begin
                chk("rnd_mem_addr", mem_addr_o, m_own_d ? da : ia);
                chk("rnd_mem_we", mem_we_o, m_own_d ? dwe : 1'b0);
                chk("rnd_mem_be", mem_be_o, m_own_d ? dbe : 8'hFF);
                chk("rnd_mem_wdata", mem_wdata_o, m_own_d ? dw : 64'h0);
            end
            if (e_ir) chk("rnd_i_rdata", i_rdata_o, m_i_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
            if (e_dr) chk("rnd_d_rdata", d_rdata_o, mem_rdata_i);

            if (e_ig || !i_pend) m_starve = 0;
            else if (e_dg && m_starve < STARVE_MAX) m_starve++;
            if (i_pend && !e_ig) pi_m++;
            if (d_pend && !e_dg) pd_m++;
            if (e_ig) i_pend = 0;
            if (e_dg) d_pend = 0;
            if (e_ig || e_dg) begin
                mem_out = 1;
                mem_lat = $urandom_range(0, 2);
            end
            m_phase = nxt;
        end
        step();
        drive_idle();
        settle();
`ifdef MEM_ARB_PERF_CNT_EN
        chk("rnd_perf_i", perf_i_stall_o, pi_m);
        chk("rnd_perf_d", perf_d_stall_o, pd_m);
`else
        chk("rnd_perf_i_off", perf_i_stall_o, 0);
        chk("rnd_perf_d_off", perf_d_stall_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
